// File: rtl/dma_upstream_writer.sv
// dma_upstream_writer: BAR-programmed DMA issuing data MWr TLPs then a completion-token MWr.
module dma_upstream_writer #(
  parameter int TLP_QWS = 16,
  parameter int DATA_OFFSET = 64,
  parameter logic [63:0] TOKEN = 64'hCAFEF00DC0DEFACE
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [15:0] cfgBusDev_in,
  input  logic        cpuWrValid_in,
  input  logic [5:0]  cpuWrAddr_in,
  input  logic [31:0] cpuWrData_in,
  input  logic [5:0]  cpuRdAddr_in,
  output logic [31:0] cpuRdData_out,
  input  logic [63:0] srcData_in,
  input  logic        srcValid_in,
  output logic        srcReady_out,
  output logic [63:0] txData_out,
  output logic        txValid_out,
  output logic        txSOP_out,
  output logic        txEOP_out,
  input  logic        txReady_in,
  output logic        busy_out
);
  localparam int BW = $clog2(TLP_QWS + 1);
  localparam logic [9:0] DATA_LEN = 10'(2 * TLP_QWS);
  localparam logic [BW-1:0] LAST = BW'(TLP_QWS - 1);
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, TOK_HDR0, TOK_HDR1, TOK_DATA} state_t;
  state_t state, state_nxt;
  logic [31:0] dma_base, counter, remaining, addr, dw0, dw1;
  logic [BW-1:0] beat;
  logic busy, start, tx_fire, last_beat, tok;
  assign busy = state != IDLE;
  assign busy_out = busy;
  assign start = !busy && cpuWrValid_in && cpuWrAddr_in == 6'd1 && cpuWrData_in != 32'd0;
  assign tok = state == TOK_HDR0 || state == TOK_HDR1 || state == TOK_DATA;
  assign last_beat = beat == LAST;
  assign dw0 = {3'b010, 19'd0, tok ? 10'd2 : DATA_LEN};
  assign dw1 = {cfgBusDev_in, 8'h00, 4'hF, 4'hF};
  assign tx_fire = txValid_out && txReady_in;
  always_comb begin
    txValid_out = state == DATA ? srcValid_in : busy;
    srcReady_out = state == DATA && txReady_in;
    txSOP_out = state == HDR0 || state == TOK_HDR0;
    txEOP_out = (state == DATA && last_beat) || state == TOK_DATA;
    txData_out = 64'd0;
    case (state)
      HDR0, TOK_HDR0: txData_out = {dw1, dw0};
      HDR1:           txData_out = {32'd0, addr};
      TOK_HDR1:       txData_out = {32'd0, dma_base};
      DATA:           txData_out = srcData_in;
      TOK_DATA:       txData_out = TOKEN;
      default:        txData_out = 64'd0;
    endcase
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     state_nxt = start ? HDR0 : IDLE;
      HDR0:     state_nxt = tx_fire ? HDR1 : HDR0;
      HDR1:     state_nxt = tx_fire ? DATA : HDR1;
      DATA:     state_nxt = tx_fire && last_beat ? (remaining > 32'd1 ? HDR0 : TOK_HDR0) : DATA;
      TOK_HDR0: state_nxt = tx_fire ? TOK_HDR1 : TOK_HDR0;
      TOK_HDR1: state_nxt = tx_fire ? TOK_DATA : TOK_HDR1;
      TOK_DATA: state_nxt = tx_fire ? IDLE : TOK_DATA;
      default:  state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state <= IDLE;
      dma_base <= 32'd0;
      counter <= 32'd0;
      remaining <= 32'd0;
      addr <= 32'd0;
      beat <= '0;
      cpuRdData_out <= 32'd0;
    end else begin
      state <= state_nxt;
      cpuRdData_out <= cpuRdAddr_in == 6'd0 ? dma_base : cpuRdAddr_in == 6'd1 ? counter : 32'd0;
      if (!busy && cpuWrValid_in && cpuWrAddr_in == 6'd0)
        dma_base <= {cpuWrData_in[31:3], 3'b000};
      if (start) begin
        remaining <= cpuWrData_in;
        addr <= dma_base + 32'(DATA_OFFSET);
      end
      if (state == DATA && tx_fire)
        beat <= last_beat ? '0 : beat + 1'b1;
      if (state == DATA && tx_fire && last_beat) begin
        addr <= addr + 32'(TLP_QWS * 8);
        remaining <= remaining - 32'd1;
      end
      if (state == TOK_DATA && tx_fire)
        counter <= counter + 32'd1;
    end
  end
endmodule
